// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle controller: fetch/decode/exec/mem/wb over a single req/ack memory port
// Register file, ALU with {V,C,Z,S} flags, loads/stores, branches, IN/OUT and HALT.
module multicycle_controller #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [3:0]        flags
);

  localparam int MSB = DATA_W - 1;
  // Slots at or above NREGS read as zero and never take a write.
  localparam logic [7:0] REG_MASK = 8'((1 << NREGS) - 1);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] rf [8];
  logic [ADDR_W-1:0] pc, ea;
  logic [15:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr;
  logic              running;

  logic [1:0]        cls;
  logic [3:0]        op;
  logic [2:0]        ra, rb;
  logic [DATA_W-1:0] imm_d;
  logic [ADDR_W-1:0] imm_a;
  logic              xfer;

  assign cls   = ir[15:14];
  assign op    = ir[7:4];
  assign ra    = ir[10:8];
  assign rb    = ir[13:11];
  assign imm_d = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign imm_a = {{(ADDR_W-8){ir[7]}}, ir[7:0]};
  assign xfer  = mem_req && mem_ack;
  assign mem_wdata = b_q;

  function automatic logic [DATA_W-1:0] rd_reg(input logic [2:0] idx);
    return REG_MASK[idx] ? rf[idx] : '0;
  endfunction

  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v, alu_setf, alu_wb;

  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_setf = 1'b0;
    alu_wb   = 1'b0;
    case (op)
      4'b0000: begin
        {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
        alu_v = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
        alu_setf = 1'b1; alu_wb = 1'b1;
      end
      4'b0001, 4'b0101: begin
        {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
        alu_v = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
        alu_setf = 1'b1; alu_wb = (op == 4'b0001);
      end
      4'b0010: begin alu_res = a_q & b_q; alu_setf = 1'b1; alu_wb = 1'b1; end
      4'b0011: begin alu_res = a_q | b_q; alu_setf = 1'b1; alu_wb = 1'b1; end
      4'b0100: begin alu_res = a_q ^ b_q; alu_setf = 1'b1; alu_wb = 1'b1; end
      4'b0110: begin alu_res = b_q; alu_wb = 1'b1; end
      4'b1000: begin alu_res = a_q << ir[3:0]; alu_setf = 1'b1; alu_wb = 1'b1; end
      4'b1010: begin alu_res = $signed(a_q) >>> ir[3:0]; alu_setf = 1'b1; alu_wb = 1'b1; end
      4'b1100: begin alu_res = in_data; alu_wb = 1'b1; end
      default: ;
    endcase
  end

  logic take;
  always_comb begin
    case (ra)
      3'b000:  take = flags[1];
      3'b001:  take = flags[0] ^ flags[3];
      3'b010:  take = flags[1] | (flags[0] ^ flags[3]);
      3'b011:  take = !flags[1];
      default: take = 1'b0;
    endcase
  end

  logic              rf_we;
  logic [2:0]        rf_idx;
  logic [DATA_W-1:0] rf_val;

  always_comb begin
    rf_we  = 1'b0;
    rf_idx = ra;
    rf_val = alu_q;
    if (state == EXEC && cls == 2'b10 && rb == 3'b000) begin
      rf_we  = 1'b1;
      rf_val = imm_d;
    end else if (state == WB) begin
      rf_we = 1'b1;
      if (cls != 2'b11) begin
        rf_idx = rb;
        rf_val = mdr;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  if (xfer) state_nxt = DECODE;
      DECODE: state_nxt = EXEC;
      EXEC: begin
        if (cls == 2'b11) begin
          if (op == 4'b1111)  state_nxt = HALT;
          else if (alu_wb)    state_nxt = WB;
          else                state_nxt = FETCH;
        end else if (cls == 2'b10) state_nxt = FETCH;
        else                       state_nxt = MEM;
      end
      MEM:     if (xfer) state_nxt = ir[14] ? FETCH : WB;
      WB:      state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // The first fetch waits for one edge after reset release, hence the running gate.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    halted   = 1'b0;
    case (state)
      FETCH: mem_req = running;
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = ir[14];
        mem_addr = ea;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running   <= 1'b0;
      pc        <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr       <= '0;
      ea        <= '0;
      flags     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      running   <= 1'b1;
      out_valid <= 1'b0;
      if (rf_we && REG_MASK[rf_idx]) rf[rf_idx] <= rf_val;
      case (state)
        FETCH: if (xfer) begin
          ir <= mem_rdata[15:0];
          pc <= pc + ADDR_W'(1);
        end
        DECODE: begin
          a_q <= rd_reg(ra);
          b_q <= rd_reg(rb);
        end
        EXEC: begin
          if (cls == 2'b11) begin
            alu_q <= alu_res;
            if (alu_setf) flags <= {alu_v, alu_c, (alu_res == '0), alu_res[MSB]};
            if (op == 4'b1101) begin
              out_data  <= b_q;
              out_valid <= 1'b1;
            end
          end else if (!cls[1]) begin
            ea <= ADDR_W'(a_q + imm_d);
          end else if (rb == 3'b100 || (rb == 3'b111 && take)) begin
            pc <= pc + imm_a;
          end
        end
        MEM: if (xfer && !ir[14]) mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule
